hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the IF/ID front end.
- Generates PC_write, IF_ID_write, IF_ID_flush and control_sel from three sources: load-use hazards, taken branches resolved in EX, and data/instruction memory busy.
- Also owns a global freeze, a memory-busy timeout watchdog, and saturating stall, flush and freeze performance counters.
- Sits beside the IF/ID/EX datapath; its outputs drive the fetch, IF/ID register and ID control-mux inputs directly.

Parameters:
- CNT_W, 16, width of each performance counter.
- TIMEOUT, 64, maximum number of consecutive mem_busy cycles before a timeout error is raised.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-low reset.
- MemRead_EX  in  1  instruction in EX is a load.
- RD_EX  in  5  destination register of the instruction in EX.
- RS1_ID  in  5  source register 1 of the instruction in ID.
- RS2_ID  in  5  source register 2 of the instruction in ID.
- OPCODE_ID  in  7  opcode of the instruction in ID.
- PCSrc_EX  in  1  branch taken, resolved in EX.
- mem_busy  in  1  memory not ready; the whole pipeline must hold.
- cnt_clear  in  1  synchronous clear of all counters.
- PC_write  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID register load enable.
- IF_ID_flush  out  1  load a NOP (0x00000013) into IF/ID.
- control_sel  out  1  1 = zero the ID control signals (bubble).
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cnt  out  CNT_W  number of load-use stall cycles.
- flush_cnt  out  CNT_W  number of branch flushes.
- freeze_cnt  out  CNT_W  number of mem_busy freeze cycles.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- State register: RUN, FREEZE, ERROR. Outputs are Mealy: a function of the current state and the current-cycle inputs, with no added latency.
- Reset (reset==0 at a clk edge):
  - State = RUN; all counters = 0; timeout_err = 0; wd_cnt = 0.
  - While reset is low, outputs are forced to PC_write=0, IF_ID_write=0, IF_ID_flush=0, control_sel=1, pipe_freeze=0.
  - Reset asserted mid-freeze or mid-error returns the block to RUN on the next edge.
- Source-usage decode on OPCODE_ID:
  - rs1 is used unless the opcode is 0110111 (LUI), 0010111 (AUIPC) or 1101111 (JAL).
  - rs2 is used only for 0110011, 0100011 and 1100011.
- Load-use hazard (lu): MemRead_EX and RD_EX!=0 and ((rs1 used and RD_EX==RS1_ID) or (rs2 used and RD_EX==RS2_ID)).
- Priority when more than one condition is true: ERROR > mem_busy > PCSrc_EX > lu > normal.
- ERROR: PC_write=0, IF_ID_write=0, pipe_freeze=1, control_sel=1, IF_ID_flush=0. The block stays in ERROR until reset.
- mem_busy=1 (state RUN or FREEZE):
  - Outputs: PC_write=0, IF_ID_write=0, pipe_freeze=1, control_sel=0, IF_ID_flush=0. A pending PCSrc_EX or lu is not acted on and is re-evaluated after the freeze.
  - Next state = FREEZE; wd_cnt increments.
  - If wd_cnt==TIMEOUT-1 while mem_busy is still 1, next state = ERROR and timeout_err <= 1.
- mem_busy=0 in FREEZE: wd_cnt <= 0, state <= RUN, and the same cycle evaluates as RUN.
- PCSrc_EX=1: PC_write=1 (branch target loads), IF_ID_write=1, IF_ID_flush=1, control_sel=1, pipe_freeze=0. One cycle only; this kills both wrong-path instructions. An lu in the same cycle is discarded (its instruction is flushed).
- lu: PC_write=0, IF_ID_write=0, control_sel=1, IF_ID_flush=0. Lasts exactly one cycle, because the load advances to MEM.
- Normal: PC_write=1, IF_ID_write=1, IF_ID_flush=0, control_sel=0, pipe_freeze=0.
- Counters:
  - stall_cnt increments on each lu cycle that is actually taken; flush_cnt on each taken PCSrc_EX cycle; freeze_cnt on each mem_busy cycle (including the cycle that causes ERROR).
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - cnt_clear has priority over increment in the same cycle; it does not clear timeout_err or state.
- Register x0 never creates a hazard.

Test Plan:
- Reset held low 3 cycles, then released, no hazards -> PC_write=0 and control_sel=1 during reset; first cycle after release PC_write=1, IF_ID_write=1; all counters 0.
- MemRead_EX=1, RD_EX=5, RS1_ID=5, OPCODE_ID=0110011 for one cycle -> that cycle PC_write=0, IF_ID_write=0, control_sel=1; stall_cnt=1. Same stimulus with RD_EX=0, or with OPCODE_ID=0110111 -> no stall.
- PCSrc_EX=1 together with a load-use match -> IF_ID_flush=1, control_sel=1, PC_write=1; flush_cnt=1, stall_cnt=0.
- mem_busy high 4 cycles with PCSrc_EX=1 throughout -> 4 cycles of pipe_freeze=1, PC_write=0; freeze_cnt=4; on the 5th cycle the flush executes and flush_cnt=1.
- mem_busy held 64 cycles, TIMEOUT=64 -> timeout_err=1 after the 64th edge; state ERROR with outputs frozen even after mem_busy drops; reset clears it.
- With CNT_W=4, 20 lu cycles then cnt_clear coincident with an lu -> stall_cnt saturates at 15, then reads 0 after the clear.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Sequencing controller for the IF/ID front end of the pipeline. It combines
// three conditions into the fetch and IF/ID control signals:
//   - load-use hazards between the load in EX and the instruction in ID
//   - taken branches that resolve in EX
//   - memory busy, which holds the whole pipeline
// It also provides a global freeze, a memory-busy watchdog, and saturating
// performance counters.
//
// The outputs are Mealy. They are a function of the current state and the
// inputs of the current cycle, and they add no latency.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low reset
//   MemRead_EX   instruction in EX is a load
//   RD_EX        destination register of the instruction in EX
//   RS1_ID       source register 1 of the instruction in ID
//   RS2_ID       source register 2 of the instruction in ID
//   OPCODE_ID    opcode of the instruction in ID
//   PCSrc_EX     branch taken, resolved in EX
//   mem_busy     memory not ready; the whole pipeline holds
//   cnt_clear    synchronous clear of all performance counters
//   PC_write     PC update enable
//   IF_ID_write  IF/ID register load enable
//   IF_ID_flush  load a NOP (0x00000013) into IF/ID
//   control_sel  1 = zero the ID control signals (insert a bubble)
//   pipe_freeze  hold ID/EX, EX/MEM and MEM/WB
//   stall_cnt    number of load-use stall cycles taken
//   flush_cnt    number of branch flushes taken
//   freeze_cnt   number of mem_busy freeze cycles
//   timeout_err  sticky watchdog error; cleared only by reset
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_EX,
    input  logic [4:0]       RD_EX,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic [6:0]       OPCODE_ID,
    input  logic             PCSrc_EX,
    input  logic             mem_busy,
    input  logic             cnt_clear,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             control_sel,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic             timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        ERROR  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd_cnt, wd_nxt;
    logic            timeout_nxt;
    logic            rs1_used, rs2_used, lu;
    logic            stall_inc, flush_inc, freeze_inc;

    // -----------------------------------------------------------------------
    // Source-usage decode and load-use detection.
    // x0 is hard-wired to zero, so a load that targets x0 never creates a
    // hazard.
    // -----------------------------------------------------------------------
    always_comb begin
        rs1_used = !(OPCODE_ID == OP_LUI || OPCODE_ID == OP_AUIPC ||
                     OPCODE_ID == OP_JAL);
        rs2_used = (OPCODE_ID == OP_RTYPE || OPCODE_ID == OP_STORE ||
                    OPCODE_ID == OP_BRANCH);
        lu = MemRead_EX && (RD_EX != 5'd0) &&
             ((rs1_used && RD_EX == RS1_ID) || (rs2_used && RD_EX == RS2_ID));
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic.
    // Priority: ERROR > mem_busy > PCSrc_EX > lu > normal.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default here, before any branch. This
        // keeps the block purely combinational, so no latch is inferred.
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        control_sel = 1'b0;
        pipe_freeze = 1'b0;
        state_nxt   = state;
        wd_nxt      = wd_cnt;
        timeout_nxt = timeout_err;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        freeze_inc  = 1'b0;

        if (!reset) begin
            // While reset is held, hold fetch and insert bubbles.
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            control_sel = 1'b1;
        end else if (state == ERROR) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            control_sel = 1'b1;
            pipe_freeze = 1'b1;
        end else if (mem_busy) begin
            // A pending branch or load-use is ignored here. It is seen
            // again once the memory is ready.
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_freeze = 1'b1;
            freeze_inc  = 1'b1;
            if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                state_nxt   = ERROR;
                timeout_nxt = 1'b1;
            end else begin
                state_nxt = FREEZE;
                wd_nxt    = wd_cnt + 1'b1;
            end
        end else begin
            // Memory is ready. Leaving FREEZE, this cycle is evaluated as RUN.
            state_nxt = RUN;
            wd_nxt    = '0;
            if (PCSrc_EX) begin
                // A taken branch kills both wrong-path instructions. Any
                // load-use seen in this cycle belongs to a flushed
                // instruction, so it is dropped.
                IF_ID_flush = 1'b1;
                control_sel = 1'b1;
                flush_inc   = 1'b1;
            end else if (lu) begin
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                control_sel = 1'b1;
                stall_inc   = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State, watchdog and sticky error registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the edge.
        if (!reset) begin
            state       <= RUN;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            wd_cnt      <= wd_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Saturating performance counters. A clear takes priority over an
    // increment in the same cycle. A counter holds once it reaches all-ones.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset || cnt_clear) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (stall_inc && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
            if (freeze_inc && !(&freeze_cnt))
                freeze_cnt <= freeze_cnt + 1'b1;
        end
    end

endmodule
